irq_arb: RTL and testbench

IRQ_ARB -- requirements
Module: irq_arb

---
 rtl/irq_arb.sv | 134 +++++++++++++
 tb/tb_irq_arb.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_arb.sv
// Fixed-priority interrupt arbiter: pending register, IDLE/REQ/ACTIVE handshake to the core.
// Optional macro IRQ_ARB_EDGE_DETECT_EN makes external lines edge-triggered instead of level.
module irq_arb #(
    parameter int unsigned IRQ_NUM_POW   = 4,
    parameter int unsigned TIMER_IRQ_NUM = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [(2**IRQ_NUM_POW)-1:0]  irq_en_bi,
    input  logic                         irq_timer_i,
    input  logic                         sgi_req_i,
    input  logic [IRQ_NUM_POW-1:0]       sgi_code_bi,
    input  logic [(2**IRQ_NUM_POW)-1:0]  irq_bi,
    output logic                         irq_req_o,
    output logic [IRQ_NUM_POW-1:0]       irq_code_bo,
    input  logic                         irq_ack_i,
    input  logic                         irq_ret_i,
    output logic [(2**IRQ_NUM_POW)-1:0]  pending_bo
);

    localparam int unsigned N = 2 ** IRQ_NUM_POW;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StActive
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [N-1:0]           r_pending;
    logic [N-1:0]           w_pending_next;
    logic [N-1:0]           w_set;
    logic [N-1:0]           w_clr;
    logic [N-1:0]           w_ext_set;
    logic [N-1:0]           w_cand;
    logic                   r_req;
    logic                   w_req_next;
    logic [IRQ_NUM_POW-1:0] r_code;
    logic [IRQ_NUM_POW-1:0] w_code_next;
    logic [IRQ_NUM_POW-1:0] w_winner;

`ifdef IRQ_ARB_EDGE_DETECT_EN
    logic [N-1:0] r_irq_prev;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_irq_prev <= '0;
        end else begin
            r_irq_prev <= irq_bi;
        end
    end

    assign w_ext_set = irq_bi & ~r_irq_prev;
`else
    assign w_ext_set = irq_bi;
`endif

    always_comb begin
        w_set = w_ext_set;
        if (irq_timer_i) begin
            w_set = w_set | (N'(1) << TIMER_IRQ_NUM);
        end
        if (sgi_req_i) begin
            w_set = w_set | (N'(1) << sgi_code_bi);
        end
    end

    assign w_cand = r_pending & irq_en_bi;

    // Lowest set index wins: scan downwards so the last hit is the smallest.
    always_comb begin
        w_winner = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_winner = IRQ_NUM_POW'(i);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req_next   = r_req;
        w_code_next  = r_code;
        w_clr        = '0;
        unique case (r_state)
            StIdle: begin
                if (|w_cand) begin
                    w_state_next = StReq;
                    w_req_next   = 1'b1;
                    w_code_next  = w_winner;
                end
            end
            StReq: begin
                if (irq_ack_i) begin
                    w_state_next = StActive;
                    w_req_next   = 1'b0;
                    w_clr        = N'(1) << r_code;
                end
            end
            StActive: begin
                if (irq_ret_i) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
                w_req_next   = 1'b0;
            end
        endcase
    end

    // Clear first, then OR in sets, so a same-cycle set survives the ack.
    assign w_pending_next = (r_pending & ~w_clr) | w_set;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state   <= StIdle;
            r_pending <= '0;
            r_req     <= 1'b0;
            r_code    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
            r_req     <= w_req_next;
            r_code    <= w_code_next;
        end
    end

    assign irq_req_o   = r_req;
    assign irq_code_bo = r_code;
    assign pending_bo  = r_pending;

endmodule

// File: tb/tb_irq_arb.sv
// Directed-vector bench for irq_arb with hand-computed expectations.
module tb_irq_arb;

    localparam int unsigned P = 4;
    localparam int unsigned N = 16;

    logic         clk_i;
    logic         rst_i;
    logic [N-1:0] irq_en_bi;
    logic         irq_timer_i;
    logic         sgi_req_i;
    logic [P-1:0] sgi_code_bi;
    logic [N-1:0] irq_bi;
    logic         irq_req_o;
    logic [P-1:0] irq_code_bo;
    logic         irq_ack_i;
    logic         irq_ret_i;
    logic [N-1:0] pending_bo;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_p7;

    irq_arb #(
        .IRQ_NUM_POW  (P),
        .TIMER_IRQ_NUM(0)
    ) u_dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .irq_en_bi  (irq_en_bi),
        .irq_timer_i(irq_timer_i),
        .sgi_req_i  (sgi_req_i),
        .sgi_code_bi(sgi_code_bi),
        .irq_bi     (irq_bi),
        .irq_req_o  (irq_req_o),
        .irq_code_bo(irq_code_bo),
        .irq_ack_i  (irq_ack_i),
        .irq_ret_i  (irq_ret_i),
        .pending_bo (pending_bo)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sgi(input logic [P-1:0] code);
        sgi_req_i   = 1'b1;
        sgi_code_bi = code;
        tick();
        sgi_req_i   = 1'b0;
    endtask

    task automatic ack_ret();
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        irq_ret_i = 1'b1;
        tick();
        irq_ret_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
    endtask

    initial begin
        irq_en_bi   = '0;
        irq_timer_i = 1'b0;
        sgi_req_i   = 1'b0;
        sgi_code_bi = '0;
        irq_bi      = '0;
        irq_ack_i   = 1'b0;
        irq_ret_i   = 1'b0;
        rst_i       = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
        check("rst_req", 32'(irq_req_o), 32'd0);
        check("rst_code", 32'(irq_code_bo), 32'd0);
        check("rst_pend", 32'(pending_bo), 32'd0);

        // SGI code 5, enabled; request two edges after the set
        irq_en_bi = 16'h0020;
        sgi(4'd5);
        check("sgi5_pend", 32'(pending_bo), 32'h20);
        check("sgi5_req_early", 32'(irq_req_o), 32'd0);
        tick();
        check("sgi5_req", 32'(irq_req_o), 32'd1);
        check("sgi5_code", 32'(irq_code_bo), 32'd5);
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        check("sgi5_ack_req", 32'(irq_req_o), 32'd0);
        check("sgi5_ack_pend", 32'(pending_bo), 32'd0);
        // ACTIVE: a new candidate must wait for ret
        sgi(4'd5);
        tick();
        check("active_wait_req", 32'(irq_req_o), 32'd0);
        check("active_wait_pend", 32'(pending_bo), 32'h20);
        irq_ret_i = 1'b1;
        tick();
        irq_ret_i = 1'b0;
        tick();
        check("after_ret_req", 32'(irq_req_o), 32'd1);
        check("after_ret_code", 32'(irq_code_bo), 32'd5);
        ack_ret();
        check("sgi5_done_pend", 32'(pending_bo), 32'd0);

        // Timer while disabled stays pending, fires once enabled
        irq_en_bi   = '0;
        irq_timer_i = 1'b1;
        tick();
        irq_timer_i = 1'b0;
        check("tmr_pend", 32'(pending_bo), 32'h1);
        tick();
        tick();
        check("tmr_dis_req", 32'(irq_req_o), 32'd0);
        irq_en_bi = 16'h0001;
        tick();
        check("tmr_en_req", 32'(irq_req_o), 32'd1);
        check("tmr_en_code", 32'(irq_code_bo), 32'd0);
        ack_ret();
        check("tmr_done_pend", 32'(pending_bo), 32'd0);

        // REQ holds code 3 while higher priority 1 arrives and enable drops
        irq_en_bi = 16'hFFFF;
        sgi(4'd3);
        tick();
        check("c3_req", 32'(irq_req_o), 32'd1);
        check("c3_code", 32'(irq_code_bo), 32'd3);
        sgi(4'd1);
        check("c3_hold_code", 32'(irq_code_bo), 32'd3);
        check("c3_hold_pend", 32'(pending_bo), 32'h0A);
        irq_en_bi = '0;
        tick();
        check("c3_en_drop_req", 32'(irq_req_o), 32'd1);
        check("c3_en_drop_code", 32'(irq_code_bo), 32'd3);
        irq_en_bi = 16'hFFFF;
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        check("c3_ack_pend", 32'(pending_bo), 32'h02);
        tick();
        check("c3_nonest_req", 32'(irq_req_o), 32'd0);
        irq_ret_i = 1'b1;
        tick();
        irq_ret_i = 1'b0;
        tick();
        check("c1_req", 32'(irq_req_o), 32'd1);
        check("c1_code", 32'(irq_code_bo), 32'd1);
        ack_ret();

        // Ack in IDLE ignored; ret in REQ ignored
        irq_en_bi = '0;
        sgi(4'd4);
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        check("idle_ack_pend", 32'(pending_bo), 32'h10);
        irq_en_bi = 16'hFFFF;
        tick();
        irq_ret_i = 1'b1;
        tick();
        irq_ret_i = 1'b0;
        check("req_ret_req", 32'(irq_req_o), 32'd1);
        check("req_ret_code", 32'(irq_code_bo), 32'd4);
        ack_ret();

        // Set and ack-clear on the same bit: set wins
        sgi(4'd2);
        tick();
        check("c2_code", 32'(irq_code_bo), 32'd2);
        irq_ack_i   = 1'b1;
        sgi_req_i   = 1'b1;
        sgi_code_bi = 4'd2;
        tick();
        irq_ack_i = 1'b0;
        sgi_req_i = 1'b0;
        check("c2_setwins_pend", 32'(pending_bo), 32'h04);
        check("c2_setwins_req", 32'(irq_req_o), 32'd0);
        irq_ret_i = 1'b1;
        tick();
        irq_ret_i = 1'b0;
        tick();
        check("c2_again_req", 32'(irq_req_o), 32'd1);
        ack_ret();

        // Simultaneous timer and SGI 9: index 0 first, then 9
        irq_timer_i = 1'b1;
        sgi(4'd9);
        irq_timer_i = 1'b0;
        check("prio_pend", 32'(pending_bo), 32'h0201);
        tick();
        check("prio_code0", 32'(irq_code_bo), 32'd0);
        ack_ret();
        tick();
        check("prio_code9", 32'(irq_code_bo), 32'd9);
        ack_ret();
        check("prio_done_pend", 32'(pending_bo), 32'd0);

        // irq_bi[7] held high 10 cycles, ack after 3
        irq_bi = 16'h0080;
        tick();
        check("ext7_pend", 32'(pending_bo), 32'h80);
        tick();
        check("ext7_code", 32'(irq_code_bo), 32'd7);
        tick();
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
`ifdef IRQ_ARB_EDGE_DETECT_EN
        exp_p7 = 32'h0;
`else
        exp_p7 = 32'h80;
`endif
        check("ext7_after_ack", 32'(pending_bo), exp_p7);
        for (int i = 0; i < 6; i++) tick();
        irq_bi = '0;
        do_reset();

        // Reset while in REQ abandons the request
        sgi(4'd6);
        tick();
        check("rst_mid_req_before", 32'(irq_req_o), 32'd1);
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        check("rst_mid_req", 32'(irq_req_o), 32'd0);
        check("rst_mid_pend", 32'(pending_bo), 32'd0);
        check("rst_mid_code", 32'(irq_code_bo), 32'd0);
        tick();
        tick();
        check("rst_no_stale", 32'(irq_req_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
